// File: rtl/add_mop_csa_acc.sv
`default_nettype none
// ============================================================================
//  Module   : add_mop_csa_acc
//  Purpose  : Multi-operand packet accumulator. Each beat of DEPTH operands is
//             folded into a carry-save pair; one carry-propagate add per packet.
//  Option   : define ADD_MOP_CSA_ACC_SAT_EN to saturate out_sum_o on overflow.
//  Revision : 1.0  initial release
// ============================================================================
module add_mop_csa_acc #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int MAX_BEATS = 4,
    parameter int OUT_WIDTH = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [DEPTH*WIDTH-1:0] in_data_i,
    input  logic                   in_last_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic [OUT_WIDTH-1:0]   out_sum_o,
    output logic                   out_ovf_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i
);

    localparam int c_iw = WIDTH + $clog2(DEPTH * MAX_BEATS);
    localparam int c_bw = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [c_bw-1:0] c_last_beat = c_bw'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        ACC     = 2'd0,
        RESOLVE = 2'd1,
        OUT     = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_iw-1:0]   r_s;
    logic [c_iw-1:0]   r_c;
    logic [c_iw-1:0]   r_result;
    logic [c_bw-1:0]   r_beats;
    logic              w_accept;
    logic              w_end;
    logic              w_ovf;

    // Linear chain of 3:2 compressors: stored pair plus one operand per stage.
    // Dropping the carry MSB is safe because the packet total always fits c_iw.
    logic [c_iw-1:0] w_s [DEPTH+1];
    logic [c_iw-1:0] w_c [DEPTH+1];

    assign w_s[0] = r_s;
    assign w_c[0] = r_c;

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_csa
            logic [c_iw-1:0] w_op;
            assign w_op       = c_iw'(in_data_i[k*WIDTH +: WIDTH]);
            assign w_s[k+1]   = w_s[k] ^ w_c[k] ^ w_op;
            assign w_c[k+1]   = ((w_s[k] & w_c[k]) | (w_s[k] & w_op) | (w_c[k] & w_op)) << 1;
        end
    endgenerate

    assign w_accept = in_valid_i && (r_state == ACC);
    assign w_end    = w_accept && (in_last_i || (r_beats == c_last_beat));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (r_state)
            ACC: begin
                in_ready_o = 1'b1;
                if (w_end) begin
                    w_state_nxt = RESOLVE;
                end
            end
            RESOLVE: begin
                w_state_nxt = OUT;
            end
            OUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    w_state_nxt = ACC;
                end
            end
            default: begin
                w_state_nxt = ACC;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s      <= '0;
            r_c      <= '0;
            r_beats  <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_s     <= w_s[DEPTH];
                r_c     <= w_c[DEPTH];
                r_beats <= w_end ? '0 : r_beats + 1'b1;
            end
            // The pair is consumed and cleared together so the next packet starts at zero.
            if (r_state == RESOLVE) begin
                r_result <= r_s + r_c;
                r_s      <= '0;
                r_c      <= '0;
            end
        end
    end

    generate
        if (OUT_WIDTH < c_iw) begin : g_ovf
            assign w_ovf = |r_result[c_iw-1:OUT_WIDTH];
        end else begin : g_no_ovf
            assign w_ovf = 1'b0;
        end
    endgenerate

    assign out_ovf_o = w_ovf;

`ifdef ADD_MOP_CSA_ACC_SAT_EN
    assign out_sum_o = w_ovf ? {OUT_WIDTH{1'b1}} : r_result[OUT_WIDTH-1:0];
`else
    assign out_sum_o = r_result[OUT_WIDTH-1:0];
`endif

endmodule
`default_nettype wire
